// File: rtl/vga_pkg.sv
// Shared VGA timing, Tetris board geometry, colour-code type and palette.
package vga_pkg;
  localparam int H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48, H_TOTAL = 800;
  localparam int V_ACTIVE = 480, V_FP = 10, V_SYNC = 2,  V_BP = 33, V_TOTAL = 525;

  localparam int BRD_X0         = 240;
  localparam int BRD_Y0         = 80;
  localparam int BRD_CELL_SHIFT = 4;
  localparam int BRD_COLS       = 10;
  localparam int BRD_ROWS       = 20;
  localparam int BRD_BORDER     = 4;
  localparam int BRD_CELLS      = BRD_COLS * BRD_ROWS;
  localparam int VGA_IN_SKEW    = 1;

  typedef logic [2:0] code_t;

  typedef struct packed {
    logic blank_n;
    logic hs;
    logic vs;
  } sync_t;

  typedef struct packed {
    logic in_board;
    logic in_border;
    logic grid;
  } flags_t;

  function automatic logic [23:0] palette(input code_t c);
    case (c)
      3'd1:    palette = 24'h00FFFF;
      3'd2:    palette = 24'hFFFF00;
      3'd3:    palette = 24'hFF00FF;
      3'd4:    palette = 24'h00FF00;
      3'd5:    palette = 24'hFF0000;
      3'd6:    palette = 24'h0000FF;
      3'd7:    palette = 24'hFF8000;
      default: palette = 24'h000000;
    endcase
  endfunction
endpackage

// File: rtl/board_ram_dp.sv
// Two-bank cell RAM: one write port, one synchronous read port, bank bit per port.
module board_ram_dp
  import vga_pkg::*;
#(
  parameter int DEPTH = BRD_CELLS
) (
  input  logic       clk,
  input  logic       we,
  input  logic       wbank,
  input  logic [7:0] waddr,
  input  code_t      wdata,
  input  logic       rbank,
  input  logic [7:0] raddr,
  output code_t      rdata
);
  code_t mem [2][DEPTH];

  always_ff @(posedge clk) begin
    if (we && (waddr < 8'(DEPTH))) mem[wbank][waddr] <= wdata;
    rdata <= mem[rbank][raddr];
  end
endmodule

// File: rtl/tetris_board_renderer.sv
// Board pixel-colour stage: coordinate decode, front-bank lookup, palette and
// sync re-alignment, plus VS-synchronised front/back buffer swap.
module tetris_board_renderer
  import vga_pkg::*;
#(
  parameter int BOARD_X0   = BRD_X0,
  parameter int BOARD_Y0   = BRD_Y0,
  parameter int CELL_SHIFT = BRD_CELL_SHIFT,
  parameter int COLS       = BRD_COLS,
  parameter int ROWS       = BRD_ROWS,
  parameter int BORDER     = BRD_BORDER,
  parameter int IN_SKEW    = VGA_IN_SKEW
) (
  input  logic        CLK_25,
  input  logic        RST_N,
  input  logic [10:0] X,
  input  logic [10:0] Y,
  input  logic        BLANK_N_IN,
  input  logic        HS_IN,
  input  logic        VS_IN,
  input  logic        WE,
  input  logic [7:0]  WADDR,
  input  logic [2:0]  WDATA,
  input  logic        SWAP_REQ,
  output logic        SWAP_ACK,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_BLANK_N,
  output logic        VGA_HS,
  output logic        VGA_VS
);
  localparam int SYNC_STAGES = 2 + IN_SKEW;
  localparam logic signed [11:0] X0 = 12'(BOARD_X0);
  localparam logic signed [11:0] Y0 = 12'(BOARD_Y0);
  localparam logic signed [11:0] BW = 12'(COLS << CELL_SHIFT);
  localparam logic signed [11:0] BH = 12'(ROWS << CELL_SHIFT);
  localparam logic signed [11:0] FR = 12'(BORDER);
  localparam sync_t SYNC_RST = '{blank_n: 1'b0, hs: 1'b1, vs: 1'b1};

  logic signed [11:0] rel_x, rel_y;
  logic               outer;
  logic [3:0]         col;
  logic [4:0]         row;
  logic [7:0]         raddr;
  flags_t             f_d, f_q;
  code_t              code;
  sync_t [SYNC_STAGES-1:0] sync_pipe;
  logic [23:0]        rgb_d, rgb_q;
  logic               front, vs_q, vs_fall;

  always_comb begin
    rel_x = $signed({1'b0, X}) - X0;
    rel_y = $signed({1'b0, Y}) - Y0;
    f_d.in_board = (rel_x >= 12'sd0) && (rel_x < BW) && (rel_y >= 12'sd0) && (rel_y < BH);
    outer = (rel_x >= -FR) && (rel_x < BW + FR) && (rel_y >= -FR) && (rel_y < BH + FR);
    f_d.in_border = outer && !f_d.in_board;
    f_d.grid = (rel_x[CELL_SHIFT-1:0] == '0) || (rel_y[CELL_SHIFT-1:0] == '0);
    col = rel_x[CELL_SHIFT +: 4];
    row = rel_y[CELL_SHIFT +: 5];
    // row*10 from shifts; off-board coordinates park on cell 0
    raddr = f_d.in_board ? ({row, 3'b000} + {2'b00, row, 1'b0} + {4'b0000, col}) : 8'd0;
  end

  board_ram_dp #(.DEPTH(COLS * ROWS)) u_ram (
    .clk   (CLK_25),
    .we    (WE),
    .wbank (~front),
    .waddr (WADDR),
    .wdata (WDATA),
    .rbank (front),
    .raddr (raddr),
    .rdata (code)
  );

  always_ff @(posedge CLK_25 or negedge RST_N) begin
    if (!RST_N) begin
      f_q       <= '0;
      sync_pipe <= {SYNC_STAGES{SYNC_RST}};
      rgb_q     <= '0;
    end else begin
      f_q       <= f_d;
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], sync_t'{BLANK_N_IN, HS_IN, VS_IN}};
      rgb_q     <= rgb_d;
    end
  end

  // blank tap is the one entering the output stage alongside rgb_d
  always_comb begin
    rgb_d = 24'h000000;
    if (!sync_pipe[SYNC_STAGES-2].blank_n) rgb_d = 24'h000000;
    else if (f_q.in_border)                rgb_d = 24'hFFFFFF;
    else if (f_q.in_board && code != '0)   rgb_d = palette(code);
    else if (f_q.in_board && f_q.grid)     rgb_d = 24'h404040;
    else if (f_q.in_board)                 rgb_d = 24'h202020;
  end

  assign vs_fall = vs_q & ~VS_IN;

  always_ff @(posedge CLK_25 or negedge RST_N) begin
    if (!RST_N) begin
      vs_q     <= 1'b1;
      front    <= 1'b0;
      SWAP_ACK <= 1'b0;
    end else begin
      vs_q     <= VS_IN;
      SWAP_ACK <= vs_fall & SWAP_REQ;
      if (vs_fall && SWAP_REQ) front <= ~front;
    end
  end

  assign {VGA_R, VGA_G, VGA_B} = rgb_q;
  assign VGA_BLANK_N = sync_pipe[SYNC_STAGES-1].blank_n;
  assign VGA_HS      = sync_pipe[SYNC_STAGES-1].hs;
  assign VGA_VS      = sync_pipe[SYNC_STAGES-1].vs;
endmodule

// File: tb/tb_tetris_board_renderer.sv
// Directed bench for tetris_board_renderer: reset, sync latency, rendering, swaps.
module tb_tetris_board_renderer;
  logic        CLK_25 = 1'b0;
  logic        RST_N;
  logic [10:0] X, Y;
  logic        BLANK_N_IN, HS_IN, VS_IN, WE, SWAP_REQ;
  logic [7:0]  WADDR;
  logic [2:0]  WDATA;
  logic        SWAP_ACK, VGA_BLANK_N, VGA_HS, VGA_VS;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  int passes = 0, total = 0, ack_cnt = 0, a0;

  tetris_board_renderer dut (
    .CLK_25(CLK_25), .RST_N(RST_N), .X(X), .Y(Y), .BLANK_N_IN(BLANK_N_IN),
    .HS_IN(HS_IN), .VS_IN(VS_IN), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .SWAP_REQ(SWAP_REQ), .SWAP_ACK(SWAP_ACK), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B), .VGA_BLANK_N(VGA_BLANK_N), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS)
  );

  always #20 CLK_25 = ~CLK_25;

  always @(negedge CLK_25) if (SWAP_ACK === 1'b1) ack_cnt++;

  initial begin
    #10ms;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic pix(input int x, input int y, input logic [23:0] exp);
    @(negedge CLK_25);
    X = 11'(x); Y = 11'(y);
    @(posedge CLK_25); @(posedge CLK_25); #1;
    chk($sformatf("rgb(%0d,%0d)", x, y), {8'h00, VGA_R, VGA_G, VGA_B}, {8'h00, exp});
  endtask

  task automatic write_cell(input int a, input int d);
    @(negedge CLK_25);
    WE = 1'b1; WADDR = 8'(a); WDATA = 3'(d);
    @(negedge CLK_25);
    WE = 1'b0;
  endtask

  task automatic vsync(input logic exp_ack);
    @(negedge CLK_25);
    VS_IN = 1'b0;
    @(posedge CLK_25); #1 chk("swap_ack", {31'd0, SWAP_ACK}, {31'd0, exp_ack});
    @(posedge CLK_25); #1 chk("ack_one_cycle", {31'd0, SWAP_ACK}, 32'd0);
    @(negedge CLK_25);
    VS_IN = 1'b1;
    repeat (2) @(negedge CLK_25);
  endtask

  initial begin
    RST_N = 1'b0; X = '0; Y = '0; BLANK_N_IN = 1'b0; HS_IN = 1'b1; VS_IN = 1'b1;
    WE = 1'b0; WADDR = '0; WDATA = '0; SWAP_REQ = 1'b0;

    // reset held 5 cycles with sync toggling at the input
    repeat (2) @(negedge CLK_25);
    HS_IN = 1'b0; BLANK_N_IN = 1'b1;
    repeat (3) @(negedge CLK_25);
    chk("rst_rgb", {8'h00, VGA_R, VGA_G, VGA_B}, 32'd0);
    chk("rst_hs", {31'd0, VGA_HS}, 32'd1);
    chk("rst_vs", {31'd0, VGA_VS}, 32'd1);
    chk("rst_blank", {31'd0, VGA_BLANK_N}, 32'd0);
    chk("rst_ack", {31'd0, SWAP_ACK}, 32'd0);
    HS_IN = 1'b1; BLANK_N_IN = 1'b0;
    RST_N = 1'b1;

    // output sync edges lag input edges by exactly 3 cycles
    @(negedge CLK_25);
    HS_IN = 1'b0; BLANK_N_IN = 1'b1;
    repeat (2) @(posedge CLK_25); #1;
    chk("hs_lat2", {31'd0, VGA_HS}, 32'd1);
    chk("blank_lat2", {31'd0, VGA_BLANK_N}, 32'd0);
    @(posedge CLK_25); #1;
    chk("hs_lat3", {31'd0, VGA_HS}, 32'd0);
    chk("blank_lat3", {31'd0, VGA_BLANK_N}, 32'd1);
    @(negedge CLK_25);
    HS_IN = 1'b1;
    repeat (2) @(posedge CLK_25); #1 chk("hs_rise_lat2", {31'd0, VGA_HS}, 32'd0);
    @(posedge CLK_25); #1 chk("hs_rise_lat3", {31'd0, VGA_HS}, 32'd1);

    // clear both banks (RAM is not reset)
    for (int i = 0; i < 200; i++) write_cell(i, 0);
    SWAP_REQ = 1'b1; vsync(1'b1); SWAP_REQ = 1'b0;
    chk("front_clear1", {31'd0, dut.front}, 32'd1);
    for (int i = 0; i < 200; i++) write_cell(i, 0);
    SWAP_REQ = 1'b1; vsync(1'b1); SWAP_REQ = 1'b0;
    chk("front_clear2", {31'd0, dut.front}, 32'd0);

    // cell 0 = red, cell 199 = yellow, then swap them in
    write_cell(0, 5);
    write_cell(199, 2);
    SWAP_REQ = 1'b1; vsync(1'b1); SWAP_REQ = 1'b0;
    pix(240, 80, 24'hFF0000);
    pix(247, 88, 24'hFF0000);
    pix(255, 95, 24'hFF0000);
    pix(384, 384, 24'hFFFF00);
    pix(399, 399, 24'hFFFF00);
    pix(236, 80, 24'hFFFFFF);
    pix(235, 80, 24'h000000);
    pix(403, 200, 24'hFFFFFF);
    pix(404, 200, 24'h000000);
    pix(300, 403, 24'hFFFFFF);
    pix(256, 80, 24'h404040);
    pix(260, 84, 24'h202020);
    pix(100, 100, 24'h000000);
    @(negedge CLK_25); BLANK_N_IN = 1'b0;
    @(negedge CLK_25);
    pix(247, 88, 24'h000000);
    pix(236, 80, 24'h000000);
    BLANK_N_IN = 1'b1;
    repeat (3) @(negedge CLK_25);

    // back-buffer write stays hidden until a swap
    write_cell(10, 3);
    vsync(1'b0);
    pix(244, 100, 24'h202020);
    SWAP_REQ = 1'b1; vsync(1'b1); SWAP_REQ = 1'b0;
    pix(244, 100, 24'hFF00FF);
    pix(247, 88, 24'h202020);

    // SWAP_REQ held for three frames
    a0 = ack_cnt;
    SWAP_REQ = 1'b1;
    vsync(1'b1); chk("front_f1", {31'd0, dut.front}, 32'd1);
    repeat (10) @(negedge CLK_25);
    vsync(1'b1); chk("front_f2", {31'd0, dut.front}, 32'd0);
    repeat (10) @(negedge CLK_25);
    vsync(1'b1); chk("front_f3", {31'd0, dut.front}, 32'd1);
    SWAP_REQ = 1'b0;
    repeat (10) @(negedge CLK_25);
    chk("ack_count3", 32'(ack_cnt - a0), 32'd3);
    vsync(1'b0); chk("front_noreq", {31'd0, dut.front}, 32'd1);

    // out-of-range writes dropped; write in swap cycle hits pre-swap back bank
    write_cell(200, 7);
    write_cell(255, 7);
    @(negedge CLK_25);
    VS_IN = 1'b0; SWAP_REQ = 1'b1; WE = 1'b1; WADDR = 8'd1; WDATA = 3'd6;
    @(posedge CLK_25); #1 chk("ack_we_swap", {31'd0, SWAP_ACK}, 32'd1);
    @(negedge CLK_25);
    WE = 1'b0; SWAP_REQ = 1'b0;
    @(negedge CLK_25); VS_IN = 1'b1;
    chk("front_we_swap", {31'd0, dut.front}, 32'd0);
    pix(260, 84, 24'h0000FF);
    pix(244, 100, 24'hFF00FF);
    pix(247, 88, 24'h202020);
    pix(392, 392, 24'h202020);

    // reset mid-line
    SWAP_REQ = 1'b1; vsync(1'b1);
    chk("front_pre_rst", {31'd0, dut.front}, 32'd1);
    @(negedge CLK_25); HS_IN = 1'b0;
    pix(247, 88, 24'hFF0000);
    @(negedge CLK_25);
    chk("hs_pre_rst", {31'd0, VGA_HS}, 32'd0);
    @(negedge CLK_25);
    RST_N = 1'b0;
    #1;
    chk("midrst_rgb", {8'h00, VGA_R, VGA_G, VGA_B}, 32'd0);
    chk("midrst_hs", {31'd0, VGA_HS}, 32'd1);
    chk("midrst_blank", {31'd0, VGA_BLANK_N}, 32'd0);
    a0 = ack_cnt;
    repeat (2) @(negedge CLK_25);
    RST_N = 1'b1;
    HS_IN = 1'b1;
    chk("front_post_rst", {31'd0, dut.front}, 32'd0);
    repeat (6) @(negedge CLK_25);
    chk("no_ack_post_rst", 32'(ack_cnt - a0), 32'd0);
    pix(247, 88, 24'h202020);
    vsync(1'b1);
    SWAP_REQ = 1'b0;
    chk("ack_after_rst", 32'(ack_cnt - a0), 32'd1);
    pix(247, 88, 24'hFF0000);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
